// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Two-stage pipelined adder/subtractor built on a two-level carry-lookahead
// structure with 4-bit groups and a valid/ready handshake on both sides.
//
//   Stage 1 forms per-bit propagate/generate against the (possibly inverted)
//   B operand, collapses them into per-group propagate/generate, and records
//   the effective carry-in and the mode bit.
//   Stage 2 resolves every group carry with a second-level lookahead over the
//   group terms, expands each group carry into bit carries, and produces the
//   sum, carry-out and signed overflow flag.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, clears both stages
//   in_valid   : operand set on a/b/cin/sub is valid
//   in_ready   : block accepts operands this cycle
//   a, b       : WIDTH-bit operands
//   cin        : carry-in, ignored in subtract mode
//   sub        : 0 = a + b + cin, 1 = a - b (a + ~b + 1)
//   out_valid  : sum/cout/ovf hold a valid result
//   out_ready  : downstream accepts the result
//   sum        : WIDTH-bit result
//   cout       : carry out of the MSB (in subtract mode 1 means no borrow)
//   ovf        : two's-complement signed overflow
//
// Parameters
//   WIDTH      : operand width, a multiple of 4 from 4 to 64
//
// Configuration macro
//   CLA_SATURATE_EN : when defined, an overflowing result is replaced by the
//                     signed saturation value; ovf is still reported and
//                     cout is unchanged.  Undefined builds carry the raw
//                     wrapped result with no saturation logic.
// ---------------------------------------------------------------------------
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;

  // Handshake / occupancy
  logic s1Valid_q;
  logic s2Valid_q;
  logic s1Advance;
  logic s2Advance;

  // Stage 1 next-state and registers
  logic [WIDTH-1:0] bEff;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NG-1:0]    grpG_d;
  logic [NG-1:0]    grpP_d;
  logic             cEff_d;

  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [NG-1:0]    grpG_q;
  logic [NG-1:0]    grpP_q;
  logic             cEff_q;
  logic             sub_q;

  // Stage 2 carry network and next-state
  logic             cIn;
  logic [NG:0]      grpC;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] rawSum;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // Stage 2 registers
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // A stage may load when it is empty or when its contents move on in the
  // same cycle, so a full pipeline still sustains one operation per cycle.
  assign s2Advance = !s2Valid_q || out_ready;
  assign s1Advance = !s1Valid_q || s2Advance;
  assign in_ready  = s1Advance;
  assign out_valid = s2Valid_q;

  // Subtraction is a + ~b + 1, so the mode bit both inverts B and forces
  // the carry-in, which is why cin has no effect in subtract mode.
  assign bEff   = sub ? ~b : b;
  assign p_d    = a ^ bEff;
  assign g_d    = a & bEff;
  assign cEff_d = sub | cin;

  // Group generate: the group produces a carry if some bit generates and
  // every higher bit inside the group propagates it.  Group propagate is
  // simply all four bits propagating.
  always_comb begin : grpTerms
    logic term;
    grpG_d = '0;
    grpP_d = '0;
    term   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      grpP_d[j] = &p_d[j*GROUP +: GROUP];
      for (int m = 0; m < GROUP; m++) begin
        term = g_d[j*GROUP + m];
        for (int k = 0; k < GROUP; k++) begin
          if (k > m) term = term & p_d[j*GROUP + k];
        end
        grpG_d[j] = grpG_d[j] | term;
      end
    end
  end

  // Stage 1 register; operand fields only load on a real accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      p_q       <= '0;
      g_q       <= '0;
      grpG_q    <= '0;
      grpP_q    <= '0;
      cEff_q    <= 1'b0;
      sub_q     <= 1'b0;
    end else if (s1Advance) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        p_q    <= p_d;
        g_q    <= g_d;
        grpG_q <= grpG_d;
        grpP_q <= grpP_d;
        cEff_q <= cEff_d;
        sub_q  <= sub;
      end
    end
  end

  // The registered mode bit already implies a set carry-in; folding it in
  // again keeps the subtract carry explicit at the point of use.
  assign cIn = cEff_q | sub_q;

  // Second-level lookahead: the carry into group j+1 is the OR over every
  // lower group i that generates with all groups between i and j
  // propagating, plus the carry-in when groups 0..j all propagate.  Each
  // group carry is a flat sum of products, no chaining between groups.
  always_comb begin : grpCarry
    logic acc;
    logic term;
    logic allP;
    grpC    = '0;
    grpC[0] = cIn;
    acc     = 1'b0;
    term    = 1'b0;
    allP    = 1'b0;
    for (int j = 0; j < NG; j++) begin
      acc  = 1'b0;
      allP = 1'b1;
      for (int i = 0; i < NG; i++) begin
        if (i <= j) begin
          term = grpG_q[i];
          for (int k = 0; k < NG; k++) begin
            if (k > i && k <= j) term = term & grpP_q[k];
          end
          acc  = acc | term;
          allP = allP & grpP_q[i];
        end
      end
      grpC[j+1] = acc | (allP & cIn);
    end
  end

  // Bit carries inside each group use the same lookahead form, seeded by
  // that group's carry-in from the second level.
  always_comb begin : bitCarry
    logic acc;
    logic term;
    logic allP;
    carry = '0;
    acc   = 1'b0;
    term  = 1'b0;
    allP  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      for (int m = 0; m < GROUP; m++) begin
        acc  = 1'b0;
        allP = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
          if (i < m) begin
            term = g_q[j*GROUP + i];
            for (int k = 0; k < GROUP; k++) begin
              if (k > i && k < m) term = term & p_q[j*GROUP + k];
            end
            acc  = acc | term;
            allP = allP & p_q[j*GROUP + i];
          end
        end
        carry[j*GROUP + m] = acc | (allP & grpC[j]);
      end
    end
  end

  // Overflow is the carry into the MSB differing from the carry out of it.
  assign rawSum = p_q ^ carry;
  assign cout_d = grpC[NG];
  assign ovf_d  = grpC[NG] ^ carry[WIDTH-1];

`ifdef CLA_SATURATE_EN
  // A wrapped result with its sign bit set came from a positive overflow
  // and clamps to the largest positive value; otherwise to the most
  // negative value.
  assign sum_d = !ovf_d        ? rawSum :
                 rawSum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} :
                                   {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign sum_d = rawSum;
`endif

  // Stage 2 register; results are held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (s2Advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL have parameter GROUP, fixed at 4, meaning the lookahead group size in bits; it is not user-overridable.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the operand set is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B.
REQ-009 Port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 Port sub, input, 1 bit: mode select, 0 = A+B+cin, 1 = A-B.
REQ-011 Port out_valid, output, 1 bit: the result is valid.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 Port sum, output, WIDTH bits: the result.
REQ-014 Port cout, output, 1 bit: carry-out of the MSB; in sub mode, 1 means no borrow.
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 Operands SHALL be accepted on a cycle where in_valid && in_ready; the result SHALL appear at the outputs exactly 2 cycles after acceptance when there is no backpressure.
REQ-017 Sub mode SHALL compute A + ~B + 1; cin SHALL be ignored when sub=1.
REQ-018 Stage 1 SHALL register the per-bit P = A^B' and G = A&B', the group generate/propagate of each 4-bit group, the effective carry-in, and the mode bit.
REQ-019 Stage 2 SHALL form group carries with a second-level lookahead over the group G/P (no ripple between groups), then intra-group carries and sum = P ^ C.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 Each stage SHALL hold a valid bit; stage k advances when it is empty or its successor advances; out_valid SHALL equal the stage-2 valid bit.
REQ-022 in_ready SHALL equal !s1_valid || (!s2_valid || out_ready), combinationally, giving full throughput of 1 op/cycle under out_ready=1.
REQ-023 While out_valid && !out_ready, sum, cout and ovf SHALL hold stable, and no accepted operand SHALL be lost or duplicated.
REQ-024 Simultaneous accept and drain SHALL both occur in the same cycle with no bubble inserted.
REQ-025 Results SHALL emerge in acceptance order.

Reset
REQ-026 When rst=1 at a clock edge, both stage valid bits SHALL clear, and sum, cout and ovf SHALL go to 0; out_valid SHALL be 0 in the following cycle.
REQ-027 Reset SHALL take priority over any handshake in the same cycle; in-flight operations SHALL be discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-029 Macro CLA_SATURATE_EN: when defined, a result with ovf=1 SHALL be replaced by the signed saturation value (0x7FF..F for a positive overflow, 0x800..0 for a negative overflow), with ovf still reported; cout is unaffected.
REQ-030 When CLA_SATURATE_EN is not defined, sum SHALL be the raw wrapped result and no saturation logic SHALL be present.

Verification (WIDTH=16)
REQ-031 Add a=FFFF, b=0001, cin=0 -> after 2 cycles: sum=0000, cout=1, ovf=0.
REQ-032 Sub a=8000, b=0001 -> sum=7FFF, cout=1, ovf=1 (with CLA_SATURATE_EN: sum=8000, ovf=1).
REQ-033 Add a=7FFF, b=0001, cin=1 -> sum=8001, ovf=1 (with CLA_SATURATE_EN: sum=7FFF); sub a=0003, b=0005 -> sum=FFFE, cout=0.
REQ-034 Stream 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, in order; then hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, outputs stable, and no loss on release.
REQ-035 Assert rst with 2 ops in flight -> out_valid=0 and sum=0 next cycle; the discarded ops never appear.
REQ-036 Random compare against a+b+cin / a-b for 10k ops with random in_valid/out_ready -> zero mismatches.
